ram_port_arbiter: RTL and testbench

Shares the single-port data/instruction RAM between the instruction-fetch requester and the mem-stage data requester.
- Sequences sub-word stores as read-modify-write, because the RAM only writes whole words.
- Arbitration: data requests have priority, with a bounded-starvation guarantee for fetch.
- Placement: between the core pipeline (IF stage, mem stage) and the RAM macro; replaces direct RAM drive from the mem stage.

---
 rtl/ram_port_arbiter_pkg.sv | 29 ++
 rtl/ram_byte_merge.sv | 21 ++
 rtl/ram_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter_pkg
// Brief    : Shared state encoding and RAM-control constants for the
//            fetch/data RAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ram_port_arbiter_pkg;

  // Arbiter sequencing states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_IF_RD = 2'd1,
    ST_D_RD  = 2'd2,
    ST_RMW   = 2'd3
  } arb_state_t;

  // RAM control levels shared across the memory subsystem
  localparam logic        CHIP_ENABLE   = 1'b1;
  localparam logic        CHIP_DISABLE  = 1'b0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO          = 32'h0000_0000;

  // Byte-enable pattern that covers the whole word
  localparam logic [3:0]  BE_FULL       = 4'b1111;

endpackage : ram_port_arbiter_pkg
`default_nettype wire

// File: rtl/ram_byte_merge.sv
`default_nettype none
// ============================================================================
// Module   : ram_byte_merge
// Brief    : Combinational per-byte merge of a new word into an old word,
//            selected by byte enables.
// Revision : 1.0 - initial release
// ============================================================================
module ram_byte_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  be,
  output logic [31:0] merged_word
);

  // Each lane takes the new byte where enabled, otherwise keeps the old byte
  for (genvar g = 0; g < 4; g++) begin : g_lane
    assign merged_word[8*g +: 8] = be[g] ? new_word[8*g +: 8] : old_word[8*g +: 8];
  end

endmodule : ram_byte_merge
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Brief    : Shares one single-port RAM between instruction fetch and the
//            mem-stage data port. Data has priority, fetch is guaranteed a
//            slot after D_BURST consecutive data grants. Sub-word stores are
//            sequenced as read-modify-write.
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int D_BURST    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [3:0]            d_be_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_wdata_i,
  output logic                  d_gnt_o,
  output logic                  d_rvalid_o,
  output logic [DATA_WIDTH-1:0] d_rdata_o,
  output logic                  ram_ce_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i,
  output logic                  busy_o
);

  localparam int CNT_W = $clog2(D_BURST + 1);

  arb_state_t            r_state;
  logic [CNT_W-1:0]      r_starve_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic                  w_idle;
  logic                  w_d_win;
  logic                  w_d_gnt;
  logic                  w_if_gnt;
  logic                  w_be_full;
  logic                  w_be_part;
  logic [ADDR_WIDTH-1:0] w_if_word;
  logic [ADDR_WIDTH-1:0] w_d_word;
  logic [DATA_WIDTH-1:0] w_merged;

  assign w_idle    = (r_state == ST_IDLE);
  assign w_if_word = {if_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign w_d_word  = {d_addr_i[ADDR_WIDTH-1:2], 2'b00};
  assign w_be_full = (d_be_i == BE_FULL);
  assign w_be_part = (d_be_i != 4'b0000) && !w_be_full;

  // Data wins unless fetch has already waited through a full data burst
  assign w_d_win  = d_req_i && !((r_starve_cnt == CNT_W'(D_BURST)) && if_req_i);
  assign w_d_gnt  = rst_i && w_idle && w_d_win;
  assign w_if_gnt = rst_i && w_idle && if_req_i && !w_d_win;

  ram_byte_merge u_merge (
    .old_word    (ram_rdata_i),
    .new_word    (r_wdata),
    .be          (r_be),
    .merged_word (w_merged)
  );

  // Drive RAM and requester outputs for the current state; all quiet in reset
  always_comb begin
    if_gnt_o    = w_if_gnt;
    d_gnt_o     = w_d_gnt;
    if_rvalid_o = 1'b0;
    if_rdata_o  = ZERO;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = ZERO;
    ram_ce_o    = CHIP_DISABLE;
    ram_we_o    = WRITE_DISABLE;
    ram_addr_o  = ZERO;
    ram_wdata_o = ZERO;
    busy_o      = rst_i && !w_idle;
    if (rst_i) begin
      case (r_state)
        ST_IDLE: begin
          if (w_if_gnt) begin
            ram_ce_o   = CHIP_ENABLE;
            ram_addr_o = w_if_word;
          end else if (w_d_gnt) begin
            if (!d_we_i || w_be_part) begin
              // Load, or the read half of a sub-word store
              ram_ce_o   = CHIP_ENABLE;
              ram_addr_o = w_d_word;
            end else if (w_be_full) begin
              ram_ce_o    = CHIP_ENABLE;
              ram_we_o    = WRITE_ENABLE;
              ram_addr_o  = w_d_word;
              ram_wdata_o = d_wdata_i;
            end
          end
        end
        ST_IF_RD: begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = ram_rdata_i;
        end
        ST_D_RD: begin
          d_rvalid_o = 1'b1;
          d_rdata_o  = ram_rdata_i;
        end
        ST_RMW: begin
          ram_ce_o    = CHIP_ENABLE;
          ram_we_o    = WRITE_ENABLE;
          ram_addr_o  = r_addr;
          ram_wdata_o = w_merged;
        end
        default: ;
      endcase
    end
  end

  // Sequence state, track fetch starvation and latch sub-word store fields
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= ST_IDLE;
      r_starve_cnt <= '0;
      r_addr       <= '0;
      r_be         <= '0;
      r_wdata      <= '0;
    end else begin
      if (!if_req_i || w_if_gnt) begin
        r_starve_cnt <= '0;
      end else if (w_d_gnt) begin
        r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_if_gnt) begin
            r_state <= ST_IF_RD;
          end else if (w_d_gnt) begin
            if (!d_we_i) begin
              r_state <= ST_D_RD;
            end else if (w_be_part) begin
              r_state <= ST_RMW;
              r_addr  <= w_d_word;
              r_be    <= d_be_i;
              r_wdata <= d_wdata_i;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : ram_port_arbiter
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Brief    : Directed self-checking bench for ram_port_arbiter with a
//            behavioural single-port RAM (read data one cycle after access).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        ram_ce_o;
  logic        ram_we_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic [31:0] ram_rdata_i;
  logic        busy_o;

  int total = 0;
  int bad   = 0;

  // RAM model plus a preload port driven by the stimulus
  logic [31:0] mem [1024];
  logic        pl_en   = 1'b0;
  logic [31:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    if (pl_en) begin
      mem[pl_addr[11:2]] <= pl_data;
    end else if (ram_ce_o && ram_we_o) begin
      mem[ram_addr_o[11:2]] <= ram_wdata_o;
    end
    if (ram_ce_o && !ram_we_o) begin
      ram_rdata_i <= mem[ram_addr_o[11:2]];
    end
  end

  ram_port_arbiter #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .D_BURST    (4)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .d_req_i     (d_req_i),
    .d_we_i      (d_we_i),
    .d_be_i      (d_be_i),
    .d_addr_i    (d_addr_i),
    .d_wdata_i   (d_wdata_i),
    .d_gnt_o     (d_gnt_o),
    .d_rvalid_o  (d_rvalid_o),
    .d_rdata_o   (d_rdata_o),
    .ram_ce_o    (ram_ce_o),
    .ram_we_o    (ram_we_o),
    .ram_addr_o  (ram_addr_o),
    .ram_wdata_o (ram_wdata_o),
    .ram_rdata_i (ram_rdata_i),
    .busy_o      (busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  task automatic d_drive(input logic we, input logic [3:0] be, input logic [31:0] a, input logic [31:0] wd);
    d_req_i   = 1'b1;
    d_we_i    = we;
    d_be_i    = be;
    d_addr_i  = a;
    d_wdata_i = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    rst_i     = 1'b0;
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    d_req_i   = 1'b1;
    d_we_i    = 1'b0;
    d_be_i    = 4'h0;
    d_addr_i  = 32'h200;
    d_wdata_i = 32'h0;
    ram_rdata_i = 32'h0;

    // Preload RAM while reset is held; outputs must stay quiet despite requests
    preload(32'h100, 32'hDEADBEEF);
    preload(32'h200, 32'hA5A50200);
    preload(32'h204, 32'h11223344);
    preload(32'h208, 32'h55667788);
    preload(32'h400, 32'h0F0F0F0F);
    #1;
    chk("rst_if_gnt", if_gnt_o, 0);
    chk("rst_d_gnt", d_gnt_o, 0);
    chk("rst_ce", ram_ce_o, 0);
    chk("rst_busy", busy_o, 0);
    if_req_i = 1'b0;
    d_req_i  = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();

    // Fetch only, unaligned byte address maps to word 0x100
    if_req_i  = 1'b1;
    if_addr_i = 32'h102;
    #1;
    chk("f_gnt", if_gnt_o, 1);
    chk("f_d_gnt", d_gnt_o, 0);
    chk("f_ce", ram_ce_o, 1);
    chk("f_we", ram_we_o, 0);
    chk("f_addr", ram_addr_o, 32'h100);
    tick();
    if_req_i = 1'b0;
    #1;
    chk("f_rvalid", if_rvalid_o, 1);
    chk("f_rdata", if_rdata_o, 32'hDEADBEEF);
    chk("f_busy", busy_o, 1);
    chk("f_no_gnt", if_gnt_o, 0);
    tick();
    #1;
    chk("idle_ce", ram_ce_o, 0);
    chk("idle_addr", ram_addr_o, 0);
    chk("idle_if_rdata", if_rdata_o, 0);
    chk("idle_busy", busy_o, 0);

    // Contention: data first, fetch after the load completes
    if_req_i  = 1'b1;
    if_addr_i = 32'h100;
    d_drive(1'b0, 4'h0, 32'h200, 32'h0);
    #1;
    chk("c_d_gnt", d_gnt_o, 1);
    chk("c_if_gnt0", if_gnt_o, 0);
    chk("c_addr", ram_addr_o, 32'h200);
    tick();
    d_req_i = 1'b0;
    #1;
    chk("c_d_rvalid", d_rvalid_o, 1);
    chk("c_d_rdata", d_rdata_o, 32'hA5A50200);
    chk("c_if_gnt1", if_gnt_o, 0);
    tick();
    #1;
    chk("c_if_gnt2", if_gnt_o, 1);
    chk("c_d_rdata0", d_rdata_o, 0);
    tick();
    if_req_i = 1'b0;
    #1;
    chk("c_if_rdata", if_rdata_o, 32'hDEADBEEF);
    tick();

    // Byte store becomes read-modify-write using the latched fields
    d_drive(1'b1, 4'b0010, 32'h205, 32'h0000AA00);
    #1;
    chk("b_gnt", d_gnt_o, 1);
    chk("b_rd_ce", ram_ce_o, 1);
    chk("b_rd_we", ram_we_o, 0);
    chk("b_rd_addr", ram_addr_o, 32'h204);
    tick();
    d_drive(1'b1, 4'hF, 32'h0, 32'hFFFFFFFF);
    d_req_i = 1'b0;
    #1;
    chk("b_wr_we", ram_we_o, 1);
    chk("b_wr_addr", ram_addr_o, 32'h204);
    chk("b_wr_data", ram_wdata_o, 32'h1122AA44);
    chk("b_wr_busy", busy_o, 1);
    chk("b_no_rvalid", d_rvalid_o, 0);
    tick();
    d_drive(1'b0, 4'h0, 32'h204, 32'h0);
    #1;
    chk("b_ld_gnt", d_gnt_o, 1);
    tick();
    d_req_i = 1'b0;
    #1;
    chk("b_ld_rdata", d_rdata_o, 32'h1122AA44);
    tick();

    // Starvation bound: four data grants, then fetch, then data again
    if_req_i  = 1'b1;
    if_addr_i = 32'h400;
    d_drive(1'b0, 4'h0, 32'h200, 32'h0);
    for (int g = 0; g < 4; g++) begin
      #1;
      chk("s_d_gnt", d_gnt_o, 1);
      chk("s_if_wait", if_gnt_o, 0);
      tick();
      #1;
      chk("s_d_rvalid", d_rvalid_o, 1);
      tick();
    end
    #1;
    chk("s_if_gnt", if_gnt_o, 1);
    chk("s_d_held", d_gnt_o, 0);
    chk("s_if_addr", ram_addr_o, 32'h400);
    tick();
    if_req_i = 1'b0;
    #1;
    chk("s_if_rdata", if_rdata_o, 32'h0F0F0F0F);
    tick();
    #1;
    chk("s_d_resume", d_gnt_o, 1);
    tick();
    d_req_i = 1'b0;
    tick();

    // Reset during the write half of an RMW abandons the write
    d_drive(1'b1, 4'b0001, 32'h208, 32'h000000EE);
    #1;
    chk("r_gnt", d_gnt_o, 1);
    tick();
    d_req_i = 1'b0;
    rst_i   = 1'b0;
    #1;
    chk("r_we", ram_we_o, 0);
    chk("r_ce", ram_ce_o, 0);
    tick();
    rst_i = 1'b1;
    #1;
    chk("r_mem", mem[32'h208 >> 2], 32'h55667788);
    chk("r_busy", busy_o, 0);
    d_drive(1'b0, 4'h0, 32'h208, 32'h0);
    #1;
    chk("r_next_gnt", d_gnt_o, 1);
    tick();
    d_req_i = 1'b0;
    #1;
    chk("r_rdata", d_rdata_o, 32'h55667788);
    tick();

    // Back-to-back full-word stores complete in one cycle each
    d_drive(1'b1, 4'hF, 32'h300, 32'hCAFEF00D);
    #1;
    chk("w0_gnt", d_gnt_o, 1);
    chk("w0_we", ram_we_o, 1);
    chk("w0_addr", ram_addr_o, 32'h300);
    chk("w0_data", ram_wdata_o, 32'hCAFEF00D);
    tick();
    d_drive(1'b1, 4'hF, 32'h304, 32'h12345678);
    #1;
    chk("w1_gnt", d_gnt_o, 1);
    chk("w1_we", ram_we_o, 1);
    chk("w1_addr", ram_addr_o, 32'h304);
    chk("w1_data", ram_wdata_o, 32'h12345678);
    tick();
    d_req_i = 1'b0;
    #1;
    chk("w_idle_we", ram_we_o, 0);
    chk("w_idle_busy", busy_o, 0);
    d_drive(1'b0, 4'h0, 32'h300, 32'h0);
    tick();
    d_req_i = 1'b0;
    #1;
    chk("w0_rb", d_rdata_o, 32'hCAFEF00D);
    tick();
    d_drive(1'b0, 4'h0, 32'h304, 32'h0);
    tick();
    d_req_i = 1'b0;
    #1;
    chk("w1_rb", d_rdata_o, 32'h12345678);
    tick();

    // Store with no byte enables: granted, no RAM access
    d_drive(1'b1, 4'h0, 32'h308, 32'hFFFFFFFF);
    #1;
    chk("z_gnt", d_gnt_o, 1);
    chk("z_ce", ram_ce_o, 0);
    tick();
    d_req_i = 1'b0;
    #1;
    chk("z_busy", busy_o, 0);
    chk("z_rvalid", d_rvalid_o, 0);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_ram_port_arbiter
`default_nettype wire
